unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/ula_pkg.sv | 30 +++
 rtl/banco_regs.sv | 31 +++
 rtl/unidade_controle.sv | 120 ++++++++++++
 tb/tb_unidade_controle.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the control unit: ALU op codes, FSM states and
// instruction field positions.
package ula_pkg;

  typedef enum logic [1:0] {
    ULA_BEQ = 2'b00,
    ULA_SUB = 2'b01,
    ULA_ADD = 2'b10,
    ULA_SIP = 2'b11
  } ula_op_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 14;
  localparam int unsigned I_BIT    = 13;
  localparam int unsigned HALT_BIT = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 10;
  localparam int unsigned RA_MSB   = 9;
  localparam int unsigned RA_LSB   = 8;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

endpackage

// File: rtl/banco_regs.sv
// 4x8 register file: two operand read ports, one debug read port, one write
// port, asynchronous active-low clear.
module banco_regs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] addr_a,
  output logic [7:0] data_a,
  input  logic [1:0] addr_b,
  output logic [7:0] data_b,
  input  logic [1:0] addr_dbg,
  output logic [7:0] data_dbg,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data
);

  logic [7:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign data_a   = regs[addr_a];
  assign data_b   = regs[addr_b];
  assign data_dbg = regs[addr_dbg];

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches 16-bit instructions, drives an external
// combinational ALU and writes results back into a 4x8 register file.
module unidade_controle
  import ula_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic        InstReq,
  output logic [7:0]  InstAddr,
  input  logic        InstAck,
  input  logic [15:0] InstData,
  output logic [7:0]  Dado1,
  output logic [7:0]  Dado2,
  output logic [1:0]  UlaOp,
  input  logic        Zero,
  input  logic [7:0]  Resultado,
  output logic        Halted,
  input  logic [1:0]  DbgSel,
  output logic [7:0]  DbgData
);

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  res;
  logic        zf;

  logic [1:0]  op;
  logic        i_bit;
  logic        halt_bit;
  logic [1:0]  rd;
  logic [1:0]  ra;
  logic [7:0]  imm;
  logic        is_beq;
  logic [1:0]  addr_b;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        wr_en;

  assign op       = ir[OP_MSB:OP_LSB];
  assign i_bit    = ir[I_BIT];
  assign halt_bit = ir[HALT_BIT];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign ra       = ir[RA_MSB:RA_LSB];
  assign imm      = ir[IMM_MSB:IMM_LSB];
  assign is_beq   = (op == ULA_BEQ);

  // BEQ compares R[ra] with R[rd]; every other op uses rb = imm[1:0] or imm itself
  assign addr_b   = is_beq ? rd : imm[1:0];
  assign Dado1    = data_a;
  assign Dado2    = (!is_beq && i_bit) ? imm : data_b;
  assign UlaOp    = op;
  assign InstAddr = pc;
  assign wr_en    = (state == ST_WB) && !halt_bit && !is_beq;

  banco_regs u_banco_regs (
    .clk      (Clock),
    .rst_n    (Resetn),
    .addr_a   (ra),
    .data_a   (data_a),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .addr_dbg (DbgSel),
    .data_dbg (DbgData),
    .wr_en    (wr_en),
    .wr_addr  (rd),
    .wr_data  (res)
  );

  // WB raises InstReq directly so the next fetch needs no extra cycle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      res     <= '0;
      zf      <= 1'b0;
      InstReq <= 1'b0;
      Halted  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (InstReq) begin
            if (InstAck) begin
              ir      <= InstData;
              InstReq <= 1'b0;
              state   <= ST_EXEC;
            end
          end else begin
            InstReq <= Enable;
          end
        end
        ST_EXEC: begin
          res   <= Resultado;
          zf    <= Zero;
          state <= ST_WB;
        end
        ST_WB: begin
          if (halt_bit) begin
            Halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (is_beq && zf) pc <= imm;
            else              pc <= pc + 8'd1;
            InstReq <= Enable;
            state   <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed vector table, hand-written corner
// sequences and random instructions checked against an architectural model.
module tb_unidade_controle;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic        InstAck = 1'b0;
  logic [15:0] InstData = '0;
  logic [1:0]  DbgSel = '0;
  logic        Zero;
  logic [7:0]  Resultado;
  logic        InstReq;
  logic [7:0]  InstAddr;
  logic [7:0]  Dado1;
  logic [7:0]  Dado2;
  logic [1:0]  UlaOp;
  logic        Halted;
  logic [7:0]  DbgData;

  unidade_controle #(.RESET_PC(8'h00)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .InstReq   (InstReq),
    .InstAddr  (InstAddr),
    .InstAck   (InstAck),
    .InstData  (InstData),
    .Dado1     (Dado1),
    .Dado2     (Dado2),
    .UlaOp     (UlaOp),
    .Zero      (Zero),
    .Resultado (Resultado),
    .Halted    (Halted),
    .DbgSel    (DbgSel),
    .DbgData   (DbgData)
  );

  always #5 Clock = ~Clock;

  // External ALU; SIP here means "set 0xFF if Dado1 < Dado2"
  function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b10:   return a + b;
      2'b01:   return a - b;
      2'b11:   return (a < b) ? 8'hFF : 8'h00;
      default: return a - b;
    endcase
  endfunction

  always_comb begin
    Resultado = alu(UlaOp, Dado1, Dado2);
    Zero      = (Dado1 == Dado2);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural model: register array and PC, one call per instruction
  logic [7:0] m_r [4];
  logic [7:0] m_pc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00;
  endtask

  task automatic model_step(input logic [15:0] in, output logic [7:0] d1, output logic [7:0] d2,
                            output logic [1:0] op, output logic [7:0] npc, output bit halt);
    logic [1:0] rd, ra;
    logic [7:0] imm, r;
    op   = in[15:14];
    halt = in[12];
    rd   = in[11:10];
    ra   = in[9:8];
    imm  = in[7:0];
    d1   = m_r[ra];
    if (op == 2'b00)  d2 = m_r[rd];
    else if (in[13])  d2 = imm;
    else              d2 = m_r[imm[1:0]];
    r = alu(op, d1, d2);
    if (!halt) begin
      if (op == 2'b00) m_pc = (d1 == d2) ? imm : m_pc + 8'd1;
      else begin
        m_r[rd] = r;
        m_pc = m_pc + 8'd1;
      end
    end
    npc = m_pc;
  endtask

  task automatic run_instr(input string tag, input logic [15:0] instr, input int delay, input int drop_at,
                           input logic [7:0] e_addr, input logic [7:0] e_d1, input logic [7:0] e_d2,
                           input logic [1:0] e_op, input logic [7:0] e_pc, input bit e_halt,
                           input int ridx, input logic [7:0] rval);
    logic [7:0] addr0;
    int w = 0;
    while (InstReq !== 1'b1 && w < 10) begin
      @(negedge Clock);
      w++;
    end
    if (InstReq !== 1'b1) begin
      chk({tag, " req_timeout"}, {15'b0, InstReq}, 16'd1);
      return;
    end
    addr0 = InstAddr;
    chk({tag, " fetch_addr"}, InstAddr, e_addr);
    for (int c = 0; c < delay; c++) begin
      if (c == drop_at) Enable = 1'b0;
      @(negedge Clock);
      chk({tag, " req_held"}, {15'b0, InstReq}, 16'd1);
      chk({tag, " addr_held"}, InstAddr, addr0);
    end
    InstAck  = 1'b1;
    InstData = instr;
    @(negedge Clock);
    InstAck  = 1'b0;
    InstData = 16'($urandom);
    chk({tag, " dado1"}, Dado1, e_d1);
    chk({tag, " dado2"}, Dado2, e_d2);
    chk({tag, " ulaop"}, UlaOp, e_op);
    chk({tag, " req_exec"}, {15'b0, InstReq}, 16'd0);
    @(negedge Clock);
    @(negedge Clock);
    if (e_halt) begin
      chk({tag, " halted"}, {15'b0, Halted}, 16'd1);
      chk({tag, " req_halt"}, {15'b0, InstReq}, 16'd0);
    end else begin
      chk({tag, " halted"}, {15'b0, Halted}, 16'd0);
      chk({tag, " req_latency"}, {15'b0, InstReq}, {15'b0, Enable});
    end
    chk({tag, " pc"}, InstAddr, e_pc);
    if (ridx >= 0) begin
      DbgSel = 2'(ridx);
      #1;
      chk({tag, " reg"}, DbgData, rval);
    end
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      DbgSel = 2'(i);
      #1;
      chk({tag, " regfile"}, DbgData, m_r[i]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"}, {15'b0, InstReq}, 16'd0);
    chk({tag, " halted"}, {15'b0, Halted}, 16'd0);
    chk({tag, " dado1"}, Dado1, 16'h00);
    chk({tag, " dado2"}, Dado2, 16'h00);
    chk({tag, " ulaop"}, UlaOp, 16'h0);
    chk({tag, " addr"}, InstAddr, 16'h00);
    for (int i = 0; i < 4; i++) begin
      DbgSel = 2'(i);
      #1;
      chk({tag, " reg_clear"}, DbgData, 16'h00);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    int          delay;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [1:0]  op;
    logic [7:0]  pc;
    int          ridx;
    logic [7:0]  rval;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d1, d2, npc, prev_pc, a0;
    logic [1:0] op;
    bit         hl;
    logic [15:0] ins;

    tbl[0]  = '{16'hA405, 0, 8'h00, 8'h05, 2'b10, 8'h01, 1, 8'h05};
    tbl[1]  = '{16'hA805, 1, 8'h00, 8'h05, 2'b10, 8'h02, 2, 8'h05};
    tbl[2]  = '{16'h0940, 0, 8'h05, 8'h05, 2'b00, 8'h40, 2, 8'h05};
    tbl[3]  = '{16'hA901, 2, 8'h05, 8'h01, 2'b10, 8'h41, 2, 8'h06};
    tbl[4]  = '{16'h0940, 0, 8'h05, 8'h06, 2'b00, 8'h42, 2, 8'h06};
    tbl[5]  = '{16'hAD10, 0, 8'h05, 8'h10, 2'b10, 8'h43, 3, 8'h15};
    tbl[6]  = '{16'h00FF, 0, 8'h00, 8'h00, 2'b00, 8'hFF, 3, 8'h15};
    tbl[7]  = '{16'h4D01, 1, 8'h05, 8'h05, 2'b01, 8'h00, 3, 8'h00};
    tbl[8]  = '{16'hE401, 0, 8'h00, 8'h01, 2'b11, 8'h01, 1, 8'hFF};
    tbl[9]  = '{16'hA001, 0, 8'h00, 8'h01, 2'b10, 8'h02, 0, 8'h01};
    tbl[10] = '{16'hE401, 0, 8'h01, 8'h01, 2'b11, 8'h03, 1, 8'h00};

    Enable = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
    @(negedge Clock);
    chk("first_req", {15'b0, InstReq}, 16'd1);
    chk("first_addr", InstAddr, 16'h00);

    prev_pc = 8'h00;
    for (int i = 0; i < 11; i++) begin
      model_step(tbl[i].instr, d1, d2, op, npc, hl);
      run_instr($sformatf("vec%0d", i), tbl[i].instr, tbl[i].delay, -1, prev_pc,
                tbl[i].d1, tbl[i].d2, tbl[i].op, tbl[i].pc, 1'b0, tbl[i].ridx, tbl[i].rval);
      prev_pc = tbl[i].pc;
    end
    chk_all_regs("after_table");

    // Ack withheld four cycles, Enable dropped during the wait
    a0 = m_pc;
    model_step(16'hA602, d1, d2, op, npc, hl);
    run_instr("ackwait", 16'hA602, 4, 2, a0, d1, d2, op, npc, 1'b0, 1, m_r[1]);
    for (int c = 0; c < 3; c++) begin
      InstAck = 1'b1;
      @(negedge Clock);
      chk("disabled_req", {15'b0, InstReq}, 16'd0);
      chk("disabled_pc", InstAddr, npc);
    end
    InstAck = 1'b0;
    Enable  = 1'b1;

    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom) & 16'hEFFF;
      a0 = m_pc;
      model_step(ins, d1, d2, op, npc, hl);
      run_instr($sformatf("rnd%0d", n), ins, int'($urandom_range(0, 2)), -1, a0,
                d1, d2, op, npc, 1'b0, -1, 8'h00);
      chk_all_regs($sformatf("rnd%0d", n));
    end

    a0 = m_pc;
    model_step(16'hB5AA, d1, d2, op, npc, hl);
    run_instr("halt", 16'hB5AA, 0, -1, a0, d1, d2, op, npc, 1'b1, -1, 8'h00);
    for (int c = 0; c < 5; c++) begin
      InstAck = c[0];
      @(negedge Clock);
      chk("halt_stay", {15'b0, Halted}, 16'd1);
      chk("halt_noreq", {15'b0, InstReq}, 16'd0);
      chk("halt_pc", InstAddr, a0);
    end
    InstAck = 1'b0;
    chk_all_regs("halt");

    Resetn = 1'b0;
    #1;
    chk_reset_outputs("reset_halt");
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
    model_step(16'hA433, d1, d2, op, npc, hl);
    run_instr("preload", 16'hA433, 0, -1, 8'h00, d1, d2, op, npc, 1'b0, 1, 8'h33);

    // Reset in the middle of EXEC must abandon the instruction
    @(negedge Clock);
    chk("mid_req", {15'b0, InstReq}, 16'd1);
    InstAck  = 1'b1;
    InstData = 16'hA944;
    @(negedge Clock);
    InstAck = 1'b0;
    chk("mid_exec_d1", Dado1, 16'h33);
    chk("mid_exec_d2", Dado2, 16'h44);
    #2;
    Resetn = 1'b0;
    #1;
    chk_reset_outputs("reset_exec");
    @(negedge Clock);
    @(negedge Clock);
    chk_reset_outputs("reset_hold");
    Resetn = 1'b1;
    model_reset();
    @(negedge Clock);
    chk("rst_first_req", {15'b0, InstReq}, 16'd1);
    chk("rst_first_addr", InstAddr, 16'h00);
    chk_all_regs("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
